// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//   Run controller for a modulo-(CNT_MAX+1) cycle counter. It owns the count
//   register and sequences the count through a programmed number of laps.
//   Control is start / pause / stop. Each wrap is flagged, and completion is
//   signalled to the surrounding logic.
//
// Configuration macro:
//   CNT_CTRL_IRQ_EN - adds a sticky completion interrupt (o_irq) with a clear
//                     input (i_irq_clr). Undefined by default.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous active-high reset
//   i_start    in   1      start request, honoured in IDLE/DONE
//   i_pause    in   1      level, holds the count while high
//   i_stop     in   1      abort to IDLE, clears counters
//   i_laps     in   LAP_W  laps to run, captured on an accepted start
//   i_irq_clr  in   1      (CNT_CTRL_IRQ_EN only) clears o_irq
//   o_cnt      out  CNT_W  current count
//   o_lap      out  LAP_W  laps completed
//   o_state    out  2      0=IDLE 1=RUN 2=PAUSE 3=DONE
//   o_busy     out  1      high in RUN or PAUSE
//   o_wrap     out  1      one-cycle pulse when the count shows 0 after CNT_MAX
//   o_done     out  1      high while in DONE
//   o_irq      out  1      (CNT_CTRL_IRQ_EN only) sticky, set on entry to DONE
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int CNT_MAX = 99,
    parameter int CNT_W   = 7,
    parameter int LAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_stop,
    input  logic [LAP_W-1:0] i_laps,
`ifdef CNT_CTRL_IRQ_EN
    input  logic             i_irq_clr,
    output logic             o_irq,
`endif
    output logic [CNT_W-1:0] o_cnt,
    output logic [LAP_W-1:0] o_lap,
    output logic [1:0]       o_state,
    output logic             o_busy,
    output logic             o_wrap,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LAP_W-1:0] LAP_ZERO = {LAP_W{1'b0}};
    localparam logic [LAP_W-1:0] LAP_ONE  = LAP_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic [LAP_W-1:0]   laps_q, laps_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LAP_W-1:0]   lap_inc;
    logic               start_ok;

    assign lap_inc  = lap_q + LAP_ONE;
    assign start_ok = i_start && (i_laps != LAP_ZERO);

    // Next-state and next-value logic for the run sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lap_d   = lap_q;
        laps_d  = laps_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    lap_d   = LAP_ZERO;
                end else if (start_ok) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                    lap_d   = LAP_ZERO;
                    laps_d  = i_laps;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    lap_d   = LAP_ZERO;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (cnt_q != CNT_TOP) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d  = CNT_ZERO;
                    wrap_d = 1'b1;
                    // Saturate at the programmed lap count so o_lap never wraps.
                    if (lap_q != laps_q) begin
                        lap_d = lap_inc;
                    end else begin
                        lap_d = lap_q;
                    end
                    if (lap_inc == laps_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PAUSE: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    lap_d   = LAP_ZERO;
                end else if (!i_pause) begin
                    // Resume only changes state; counting restarts next edge.
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                lap_d   = LAP_ZERO;
            end
        endcase
        // Status flags are derived from the next state so they stay registered.
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            lap_q   <= LAP_ZERO;
            laps_q  <= LAP_ZERO;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lap_q   <= lap_d;
            laps_q  <= laps_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CNT_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: entry into DONE wins over a simultaneous clear
    always_comb begin
        irq_d = irq_q;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            irq_d = 1'b1;
        end else if (i_irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_irq = irq_q;
`endif

    assign o_cnt   = cnt_q;
    assign o_lap   = lap_q;
    assign o_state = state_q;
    assign o_busy  = busy_q;
    assign o_wrap  = wrap_q;
    assign o_done  = done_q;

endmodule
